// File: rtl/csr_mtimer_if.sv
// csr_mtimer_if: single-cycle request/acknowledge data-bus port of the
// machine timer.
//   i_req   : request, one transaction per cycle it is high
//   i_we    : 1 = write, 0 = read (qualified by i_req)
//   i_addr  : byte offset (0x0/0x4 mtime lo/hi, 0x8/0xC mtimecmp lo/hi)
//   i_wdata : write data
//   o_ack   : response, exactly one cycle after the request
//   o_rdata : read data, zero whenever o_ack is low or on a write ack
//   o_err   : misaligned offset, valid with o_ack
// Modports: master drives requests, slave (the timer) drives responses.
interface csr_mtimer_if #(
  parameter int XLEN = 32
);
  logic            i_req;
  logic            i_we;
  logic [3:0]      i_addr;
  logic [XLEN-1:0] i_wdata;
  logic            o_ack;
  logic [XLEN-1:0] o_rdata;
  logic            o_err;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_ack, o_rdata, o_err
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_ack, o_rdata, o_err
  );
endinterface

// File: rtl/csr_mtimer.sv
// csr_mtimer: machine-mode timer. 64-bit free-running mtime advanced every
// PRESCALE clocks, 64-bit mtimecmp, and a registered interrupt-pending level
// o_mtip = (mtime >= mtimecmp) feeding the CSR trap logic (mip.MTIP).
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   bus    : csr_mtimer_if slave modport (request/ack register port)
//   o_mtip : machine timer interrupt pending
// Parameters: XLEN (only 32 supported), PRESCALE (1..65535).
module csr_mtimer #(
  parameter int XLEN     = 32,
  parameter int PRESCALE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  csr_mtimer_if.slave  bus,
  output logic         o_mtip
);

  localparam logic [15:0] LP_PS_MAX = 16'(PRESCALE - 1);

  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic [15:0]     r_ps;
  logic            r_ack;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;
  logic            r_mtip;

  logic            w_misal;
  logic            w_wr;
  logic            w_rd;
  logic            w_wr_mtime;
  logic            w_wr_cmp;
  logic            w_tick;
  logic [XLEN-1:0] w_rd_word;
  logic [63:0]     w_mtime_nxt;
  logic [63:0]     w_mtimecmp_nxt;
  logic [15:0]     w_ps_nxt;

  assign w_misal    = (bus.i_addr[1:0] != 2'b00);
  assign w_wr       = bus.i_req & bus.i_we & ~w_misal;
  assign w_rd       = bus.i_req & ~bus.i_we & ~w_misal;
  assign w_wr_mtime = w_wr & ~bus.i_addr[3];
  assign w_wr_cmp   = w_wr & bus.i_addr[3];
  assign w_tick     = (r_ps == LP_PS_MAX);

  always_comb begin
    w_rd_word = '0;
    case (bus.i_addr[3:2])
      2'b00:   w_rd_word = r_mtime[31:0];
      2'b01:   w_rd_word = r_mtime[63:32];
      2'b10:   w_rd_word = r_mtimecmp[31:0];
      default: w_rd_word = r_mtimecmp[63:32];
    endcase
  end

  // A write to either mtime half takes priority over a coinciding tick:
  // the counter holds exactly the written value and the prescaler restarts.
  always_comb begin
    w_mtime_nxt = r_mtime;
    w_ps_nxt    = r_ps;
    if (w_wr_mtime) begin
      if (bus.i_addr[2]) w_mtime_nxt[63:32] = bus.i_wdata;
      else               w_mtime_nxt[31:0]  = bus.i_wdata;
      w_ps_nxt = '0;
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
      w_ps_nxt    = '0;
    end else begin
      w_ps_nxt = r_ps + 16'd1;
    end
  end

  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr_cmp) begin
      if (bus.i_addr[2]) w_mtimecmp_nxt[63:32] = bus.i_wdata;
      else               w_mtimecmp_nxt[31:0]  = bus.i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_ps       <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_mtip     <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_ps       <= w_ps_nxt;
      r_ack      <= bus.i_req;
      r_err      <= bus.i_req & w_misal;
      r_rdata    <= w_rd ? w_rd_word : '0;
      // Compares the current registers, so any change shows one cycle later.
      r_mtip     <= (r_mtime >= r_mtimecmp);
    end
  end

  assign bus.o_ack   = r_ack;
  assign bus.o_err   = r_err;
  assign bus.o_rdata = r_rdata;
  assign o_mtip      = r_mtip;

endmodule

// File: tb/tb_csr_mtimer.sv
module tb_csr_mtimer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mtip1, mtip4;
  int total = 0;
  int bad   = 0;

  csr_mtimer_if #(.XLEN(32)) if1 ();
  csr_mtimer_if #(.XLEN(32)) if4 ();

  csr_mtimer #(.XLEN(32), .PRESCALE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(if1), .o_mtip(mtip1));
  csr_mtimer #(.XLEN(32), .PRESCALE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .bus(if4), .o_mtip(mtip4));

  always #5 clk = ~clk;

  // Starts at a negedge: drives the request, waits one negedge (one posedge
  // in between) and returns the response; ends at a negedge with i_req low.
  task automatic xact(input int d, input logic we, input logic [3:0] addr,
                      input logic [31:0] wdata, output logic ack,
                      output logic [31:0] rdata, output logic err);
    if (d == 4) begin
      if4.i_req = 1'b1; if4.i_we = we; if4.i_addr = addr; if4.i_wdata = wdata;
    end else begin
      if1.i_req = 1'b1; if1.i_we = we; if1.i_addr = addr; if1.i_wdata = wdata;
    end
    @(negedge clk);
    if (d == 4) begin
      ack = if4.o_ack; rdata = if4.o_rdata; err = if4.o_err; if4.i_req = 1'b0;
    end else begin
      ack = if1.o_ack; rdata = if1.o_rdata; err = if1.o_err; if1.i_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic a, e; logic [31:0] r;
    #1 rst = 1'b1;
    #1;
    total++; if (if1.o_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", if1.o_ack); end
    total++; if (if1.o_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", if1.o_rdata); end
    total++; if (mtip1 !== 1'b0 || mtip4 !== 1'b0) begin bad++; $display("FAIL rst_mtip got=%b%b exp=00", mtip1, mtip4); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    xact(1, 1'b0, 4'h0, 32'h0, a, r, e);
    total++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'd10) begin bad++; $display("FAIL idle10_lo got ack=%b err=%b data=%h exp 1 0 0000000a", a, e, r); end
    xact(1, 1'b0, 4'h4, 32'h0, a, r, e);
    total++; if (a !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL idle_hi got ack=%b data=%h exp 1 0", a, r); end
    total++; if (mtip1 !== 1'b0) begin bad++; $display("FAIL idle_mtip got=%b exp=0", mtip1); end
    xact(1, 1'b0, 4'h8, 32'h0, a, r, e);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", r); end
    xact(1, 1'b0, 4'hC, 32'h0, a, r, e);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi got=%h exp=ffffffff", r); end
  endtask

  task automatic test_prescale();
    logic a, e; logic [31:0] r;
    xact(4, 1'b1, 4'h0, 32'h0, a, r, e);
    total++; if (a !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL ps_wr_ack got ack=%b data=%h exp 1 0", a, r); end
    repeat (16) @(negedge clk);
    xact(4, 1'b0, 4'h0, 32'h0, a, r, e);
    total++; if (r !== 32'd4) begin bad++; $display("FAIL ps_16cyc got=%h exp=4", r); end
    // Re-align: after this write the prescaler reaches 3 three edges later.
    xact(4, 1'b1, 4'h0, 32'h0, a, r, e);
    repeat (3) @(negedge clk);
    xact(4, 1'b1, 4'h0, 32'h1234_5678, a, r, e);
    xact(4, 1'b0, 4'h0, 32'h0, a, r, e);
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL ps_wr_vs_tick got=%h exp=12345678", r); end
  endtask

  task automatic test_wrap();
    logic a, e; logic [31:0] r;
    xact(1, 1'b1, 4'h4, 32'hFFFF_FFFF, a, r, e);
    xact(1, 1'b1, 4'h0, 32'hFFFF_FFFE, a, r, e);
    xact(1, 1'b0, 4'h0, 32'h0, a, r, e);
    total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_lo0 got=%h exp=fffffffe", r); end
    xact(1, 1'b0, 4'h4, 32'h0, a, r, e);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_hi0 got=%h exp=ffffffff", r); end
    xact(1, 1'b0, 4'h0, 32'h0, a, r, e);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL wrap_lo got=%h exp=0", r); end
    xact(1, 1'b0, 4'h4, 32'h0, a, r, e);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h exp=0", r); end
  endtask

  task automatic test_compare();
    logic a, e; logic [31:0] r;
    xact(1, 1'b1, 4'hC, 32'h0, a, r, e);
    xact(1, 1'b1, 4'h8, 32'h20, a, r, e);
    xact(1, 1'b1, 4'h4, 32'h0, a, r, e);
    xact(1, 1'b1, 4'h0, 32'h10, a, r, e);
    repeat (16) @(negedge clk);
    total++; if (mtip1 !== 1'b0) begin bad++; $display("FAIL mtip_early got=%b exp=0", mtip1); end
    @(negedge clk);
    total++; if (mtip1 !== 1'b1) begin bad++; $display("FAIL mtip_rise got=%b exp=1", mtip1); end
    xact(1, 1'b1, 4'h8, 32'h1000, a, r, e);
    total++; if (mtip1 !== 1'b1) begin bad++; $display("FAIL mtip_hold got=%b exp=1", mtip1); end
    @(negedge clk);
    total++; if (mtip1 !== 1'b0) begin bad++; $display("FAIL mtip_fall got=%b exp=0", mtip1); end
  endtask

  task automatic test_back_to_back();
    logic a, e; logic [31:0] r;
    logic [3:0]  addrs [4] = '{4'h0, 4'h8, 4'h0, 4'hC};
    logic [31:0] exps  [4] = '{32'h100, 32'h1000, 32'h102, 32'h0};
    xact(1, 1'b1, 4'h0, 32'h100, a, r, e);
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b0, addrs[i], 32'h0, a, r, e);
      total++; if (a !== 1'b1 || e !== 1'b0 || r !== exps[i]) begin bad++; $display("FAIL b2b_%0d got ack=%b err=%b data=%h exp 1 0 %h", i, a, e, r, exps[i]); end
    end
    @(negedge clk);
    total++; if (if1.o_ack !== 1'b0 || if1.o_rdata !== 32'h0) begin bad++; $display("FAIL b2b_idle got ack=%b data=%h exp 0 0", if1.o_ack, if1.o_rdata); end
  endtask

  task automatic test_misaligned();
    logic a, e; logic [31:0] r;
    xact(1, 1'b1, 4'h6, 32'hDEAD_BEEF, a, r, e);
    total++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL mis_wr got ack=%b err=%b data=%h exp 1 1 0", a, e, r); end
    xact(1, 1'b0, 4'h4, 32'h0, a, r, e);
    total++; if (e !== 1'b0 || r !== 32'h0) begin bad++; $display("FAIL mis_unchanged got err=%b data=%h exp 0 0", e, r); end
    xact(1, 1'b0, 4'h9, 32'h0, a, r, e);
    total++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL mis_rd got ack=%b err=%b data=%h exp 1 1 0", a, e, r); end
  endtask

  task automatic test_async_reset();
    logic a, e; logic [31:0] r;
    xact(1, 1'b1, 4'h0, 32'h2000, a, r, e);
    @(negedge clk);
    total++; if (mtip1 !== 1'b1) begin bad++; $display("FAIL ar_pre_mtip got=%b exp=1", mtip1); end
    if1.i_req = 1'b1; if1.i_we = 1'b0; if1.i_addr = 4'h0; if1.i_wdata = 32'h0;
    @(posedge clk);
    #2;
    total++; if (if1.o_ack !== 1'b1) begin bad++; $display("FAIL ar_pre_ack got=%b exp=1", if1.o_ack); end
    rst = 1'b1;
    #1;
    total++; if (if1.o_ack !== 1'b0 || mtip1 !== 1'b0 || if1.o_rdata !== 32'h0) begin bad++; $display("FAIL ar_immediate got ack=%b mtip=%b data=%h exp 0 0 0", if1.o_ack, mtip1, if1.o_rdata); end
    @(negedge clk);
    if1.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (if1.o_ack !== 1'b0) begin bad++; $display("FAIL ar_no_ack got=%b exp=0", if1.o_ack); end
    xact(1, 1'b0, 4'h0, 32'h0, a, r, e);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL ar_mtime got=%h exp=1", r); end
    xact(1, 1'b0, 4'h8, 32'h0, a, r, e);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ar_cmp got=%h exp=ffffffff", r); end
  endtask

  initial begin
    if1.i_req = 1'b0; if1.i_we = 1'b0; if1.i_addr = '0; if1.i_wdata = '0;
    if4.i_req = 1'b0; if4.i_we = 1'b0; if4.i_addr = '0; if4.i_wdata = '0;
    test_reset();
    test_prescale();
    test_wrap();
    test_compare();
    test_back_to_back();
    test_misaligned();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
